// File: rtl/iob_cache_read_channel_axi_split_pkg.sv
// rtl/iob_cache_read_channel_axi_split_pkg.sv - AXI encodings, FSM states and width helpers for the line-fill engine
package iob_cache_read_channel_axi_split_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [3:0] AXI_CACHE_MODIF = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_END
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/iob_cache_read_channel_axi_split_burst_ctr.sv
// rtl/iob_cache_read_channel_axi_split_burst_ctr.sv - beat/burst index and retry counter
// The line beat index is kept as one {burst, beat} word so the last beat of a burst carries into the next burst.
module iob_cache_read_channel_axi_split_burst_ctr
   import iob_cache_read_channel_axi_split_pkg::*;
#(
   parameter int LINE2BE_W = 3,
   parameter int BURST_W   = 1,
   parameter int MAX_RETRY = 2,
   localparam int IDX_W    = max_int(LINE2BE_W, 1),
   localparam int RETRY_W  = max_int($clog2(MAX_RETRY + 1), 1)
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             clear_i,
   input  logic             beat_inc_i,
   input  logic             burst_next_i,
   input  logic             retry_i,
   output logic [IDX_W-1:0] idx_o,
   output logic [IDX_W-1:0] burst_base_o,
   output logic             beat_last_o,
   output logic             burst_last_o,
   output logic             retry_left_o
);

   localparam logic [IDX_W-1:0]   BEAT_MASK = IDX_W'((1 << BURST_W) - 1);
   localparam logic [IDX_W-1:0]   LINE_MASK = IDX_W'((1 << LINE2BE_W) - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [RETRY_W-1:0] retry_q, retry_d;

   always_comb begin
      idx_d   = idx_q;
      retry_d = retry_q;
      if (clear_i) begin
         idx_d   = '0;
         retry_d = '0;
      end else if (burst_next_i) begin
         idx_d   = (idx_q + 1'b1) & LINE_MASK;
         retry_d = '0;
      end else if (retry_i) begin
         idx_d   = idx_q & ~BEAT_MASK;
         retry_d = retry_q + 1'b1;
      end else if (beat_inc_i) begin
         idx_d   = (idx_q + 1'b1) & LINE_MASK;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idx_q   <= '0;
         retry_q <= '0;
      end else begin
         idx_q   <= idx_d;
         retry_q <= retry_d;
      end
   end

   assign idx_o        = idx_q;
   assign burst_base_o = idx_q & ~BEAT_MASK;
   assign beat_last_o  = (idx_q & BEAT_MASK) == BEAT_MASK;
   assign burst_last_o = ((idx_q | BEAT_MASK) & LINE_MASK) == LINE_MASK;
   assign retry_left_o = retry_q < RETRY_MAX;

endmodule

// File: rtl/iob_cache_read_channel_axi_split.sv
// rtl/iob_cache_read_channel_axi_split.sv - AXI4 line-fill read engine with burst splitting and bounded retry
module iob_cache_read_channel_axi_split
   import iob_cache_read_channel_axi_split_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int DATA_W        = 32,
   parameter int BE_ADDR_W     = 32,
   parameter int BE_DATA_W     = 64,
   parameter int WORD_OFFSET_W = 3,
   parameter int AXI_ID_W      = 1,
   parameter int AXI_ID        = 0,
   parameter int AXI_LEN_W     = 8,
   parameter int MAX_BURST_W   = 4,
   parameter int MAX_RETRY     = 2,
   localparam int BE_NBYTES_W  = $clog2(BE_DATA_W / 8),
   localparam int LINE2BE_W    = WORD_OFFSET_W - $clog2(BE_DATA_W / DATA_W),
   localparam int BURST_W      = min_int(LINE2BE_W, MAX_BURST_W),
   localparam int LINE_ADDR_W  = ADDR_W - BE_NBYTES_W - LINE2BE_W,
   localparam int IDX_W        = max_int(LINE2BE_W, 1)
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   replace_valid_i,
   input  logic [LINE_ADDR_W-1:0] replace_addr_i,
   output logic                   replace_o,
   output logic                   read_valid_o,
   output logic [IDX_W-1:0]       read_addr_o,
   output logic [BE_DATA_W-1:0]   read_rdata_o,
   output logic                   error_o,
   output logic [AXI_ID_W-1:0]    axi_arid_o,
   output logic [BE_ADDR_W-1:0]   axi_araddr_o,
   output logic [AXI_LEN_W-1:0]   axi_arlen_o,
   output logic [2:0]             axi_arsize_o,
   output logic [1:0]             axi_arburst_o,
   output logic                   axi_arlock_o,
   output logic [3:0]             axi_arcache_o,
   output logic [2:0]             axi_arprot_o,
   output logic [3:0]             axi_arqos_o,
   output logic                   axi_arvalid_o,
   input  logic                   axi_arready_i,
   input  logic [AXI_ID_W-1:0]    axi_rid_i,
   input  logic [BE_DATA_W-1:0]   axi_rdata_i,
   input  logic [1:0]             axi_rresp_i,
   input  logic                   axi_rlast_i,
   input  logic                   axi_rvalid_i,
   output logic                   axi_rready_o
);

   state_t                 state_q, state_d;
   logic                   err_q, err_d;
   logic                   abort_q, abort_d;
   logic [LINE_ADDR_W-1:0] addr_q, addr_d;

   logic             ctr_clear, ctr_inc, ctr_next, ctr_retry;
   logic [IDX_W-1:0] idx, burst_base;
   logic             beat_last, burst_last, retry_left;
   logic             beat_err, err_now;
   logic [ADDR_W-1:0] ar_line;

   iob_cache_read_channel_axi_split_burst_ctr #(
      .LINE2BE_W (LINE2BE_W),
      .BURST_W   (BURST_W),
      .MAX_RETRY (MAX_RETRY)
   ) u_ctr (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .clear_i      (ctr_clear),
      .beat_inc_i   (ctr_inc),
      .burst_next_i (ctr_next),
      .retry_i      (ctr_retry),
      .idx_o        (idx),
      .burst_base_o (burst_base),
      .beat_last_o  (beat_last),
      .burst_last_o (burst_last),
      .retry_left_o (retry_left)
   );

   // An rlast arriving before the burst's final beat index counts as a bad beat.
   assign beat_err = (axi_rresp_i != AXI_RESP_OKAY) || (axi_rid_i != AXI_ID_W'(AXI_ID))
                     || (axi_rlast_i && !beat_last);
   assign err_now  = err_q || beat_err;

   always_comb begin
      state_d       = state_q;
      err_d         = err_q;
      abort_d       = abort_q;
      addr_d        = addr_q;
      ctr_clear     = 1'b0;
      ctr_inc       = 1'b0;
      ctr_next      = 1'b0;
      ctr_retry     = 1'b0;
      axi_arvalid_o = 1'b0;
      axi_rready_o  = 1'b0;
      read_valid_o  = 1'b0;
      error_o       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (replace_valid_i) begin
               state_d   = ST_ADDR;
               ctr_clear = 1'b1;
               err_d     = 1'b0;
               abort_d   = 1'b0;
               addr_d    = replace_addr_i;
            end
         end
         ST_ADDR: begin
            axi_arvalid_o = 1'b1;
            if (axi_arready_i) state_d = ST_DATA;
         end
         ST_DATA: begin
            axi_rready_o = 1'b1;
            if (axi_rvalid_i) begin
               read_valid_o = 1'b1;
               if (!axi_rlast_i) begin
                  err_d   = err_now;
                  ctr_inc = !beat_last;
               end else if (!err_now) begin
                  if (burst_last) begin
                     state_d = ST_END;
                  end else begin
                     ctr_next = 1'b1;
                     state_d  = ST_ADDR;
                  end
               end else if (retry_left) begin
                  ctr_retry = 1'b1;
                  err_d     = 1'b0;
                  state_d   = ST_ADDR;
               end else begin
                  abort_d = 1'b1;
                  state_d = ST_END;
               end
            end
         end
         ST_END: begin
            error_o = abort_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         abort_q <= abort_d;
         addr_q  <= addr_d;
      end
   end

   assign ar_line = (ADDR_W'(addr_q) << (LINE2BE_W + BE_NBYTES_W))
                  | (ADDR_W'(burst_base) << BE_NBYTES_W);

   assign replace_o     = state_q != ST_IDLE;
   assign read_addr_o   = idx;
   assign read_rdata_o  = axi_rdata_i;
   assign axi_arid_o    = AXI_ID_W'(AXI_ID);
   assign axi_araddr_o  = BE_ADDR_W'(ar_line);
   assign axi_arlen_o   = AXI_LEN_W'((1 << BURST_W) - 1);
   assign axi_arsize_o  = 3'(BE_NBYTES_W);
   assign axi_arburst_o = AXI_BURST_INCR;
   assign axi_arlock_o  = 1'b0;
   assign axi_arcache_o = AXI_CACHE_MODIF;
   assign axi_arprot_o  = 3'b000;
   assign axi_arqos_o   = 4'b0000;

endmodule

// File: tb/tb_iob_cache_read_channel_axi_split.sv
// tb/tb_iob_cache_read_channel_axi_split.sv - directed scoreboard bench: split bursts, retry, abort, reset
`timescale 1ns/1ps
module tb_iob_cache_read_channel_axi_split;

   typedef struct {
      logic [2:0]  addr;
      logic [63:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        replace_valid = 1'b0;
   logic [25:0] replace_addr = '0;
   logic        replace, read_valid, error;
   logic [2:0]  read_addr;
   logic [63:0] read_rdata;
   logic [0:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst;
   logic        arlock, arvalid, rready;
   logic [3:0]  arcache, arqos;
   logic        arready = 1'b0;
   logic [0:0]  rid = '0;
   logic [63:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0, rvalid = 1'b0;

   int          n_checks = 0;
   int          n_err = 0;
   int          err_pulses = 0;
   int          ar_hs = 0;
   int          fill_tag = 0;
   beat_t       exp_q[$];
   logic [63:0] dut_ram[8];
   logic [63:0] exp_ram[8];

   always #5 clk = ~clk;

   iob_cache_read_channel_axi_split #(
      .ADDR_W(32), .DATA_W(32), .BE_ADDR_W(32), .BE_DATA_W(64), .WORD_OFFSET_W(4),
      .AXI_ID_W(1), .AXI_ID(0), .AXI_LEN_W(8), .MAX_BURST_W(1), .MAX_RETRY(2)
   ) dut (
      .clk_i(clk), .reset_n_i(rst_n),
      .replace_valid_i(replace_valid), .replace_addr_i(replace_addr), .replace_o(replace),
      .read_valid_o(read_valid), .read_addr_o(read_addr), .read_rdata_o(read_rdata), .error_o(error),
      .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
      .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache), .axi_arprot_o(arprot),
      .axi_arqos_o(arqos), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
      .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
      .axi_rvalid_i(rvalid), .axi_rready_o(rready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && read_valid) begin
         if (exp_q.size() == 0) begin
            chk("beat_spurious", 64'(exp_q.size()), 64'd1);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_addr", 64'(read_addr), 64'(e.addr));
            chk("beat_data", read_rdata, e.data);
            dut_ram[read_addr] = read_rdata;
         end
      end
      if (rst_n && error) err_pulses++;
   end

   always @(posedge clk) if (rst_n && arvalid && arready) ar_hs++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] line_base(input logic [25:0] a);
      return {a, 6'b0};
   endfunction

   task automatic start_fill(input logic [25:0] a);
      fill_tag++;
      for (int i = 0; i < 8; i++) exp_ram[i] = 'x;
      @(posedge clk); #1 replace_addr = a; replace_valid = 1'b1;
      @(posedge clk); #1 replace_valid = 1'b0;
      @(negedge clk);
      chk("replace_busy", 64'(replace), 64'd1);
   endtask

   task automatic do_ar(input logic [31:0] exp_addr, input int delay);
      int n;
      logic [19:0] cst_exp;
      n = 0;
      cst_exp = {1'b0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000};
      @(negedge clk);
      while (!arvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ar_valid", 64'(arvalid), 64'd1);
      chk("ar_addr", 64'(araddr), 64'(exp_addr));
      chk("ar_len", 64'(arlen), 64'd1);
      chk("ar_const", 64'({arid, arsize, arburst, arlock, arcache, arprot, arqos}), 64'(cst_exp));
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("ar_hold_valid", 64'(arvalid), 64'd1);
         chk("ar_hold_addr", 64'(araddr), 64'(exp_addr));
      end
      @(posedge clk); #1 arready = 1'b1;
      @(posedge clk); #1 arready = 1'b0;
   endtask

   // Two beats per burst; err_beat < 0 means a clean attempt.
   task automatic do_r(input int burst, input int attempt, input int err_beat,
                       input logic [1:0] err_resp, input logic bad_id);
      for (int b = 0; b < 2; b++) begin
         beat_t e;
         e.addr = 3'(burst * 2 + b);
         e.data = {32'(fill_tag), 16'hBEEF, 4'(burst), 4'(attempt), 8'(b)};
         rvalid = 1'b1;
         rdata  = e.data;
         rlast  = (b == 1);
         rresp  = (b == err_beat && !bad_id) ? err_resp : 2'b00;
         rid    = (b == err_beat && bad_id) ? 1'b1 : 1'b0;
         exp_q.push_back(e);
         if (err_beat < 0) exp_ram[e.addr] = e.data;
         @(posedge clk); #1;
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 1'b0;
   endtask

   task automatic end_fill(input logic exp_error);
      @(negedge clk);
      chk("end_replace", 64'(replace), 64'd1);
      chk("end_error", 64'(error), 64'(exp_error));
      chk("end_read_addr_hold", 64'(read_addr), 64'd7);
      @(negedge clk);
      chk("idle_replace", 64'(replace), 64'd0);
      chk("idle_error", 64'(error), 64'd0);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int ar0, ep0;
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_outputs", 64'({replace, arvalid, rready, read_valid, error}), 64'd0);
      chk("rst_read_addr", 64'(read_addr), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Clean fill split into four 2-beat bursts
      ar0 = ar_hs; ep0 = err_pulses;
      start_fill(26'h12);
      for (int b = 0; b < 4; b++) begin
         do_ar(line_base(26'h12) + 32'(b * 16), 0);
         do_r(b, 0, -1, 2'b00, 1'b0);
      end
      end_fill(1'b0);
      chk("clean_ar_count", 64'(ar_hs - ar0), 64'd4);
      chk("clean_no_error", 64'(err_pulses - ep0), 64'd0);

      // Retries: SLVERR on burst 1, wrong RID on rlast then DECERR on burst 2, slow arready on burst 3
      ar0 = ar_hs; ep0 = err_pulses;
      start_fill(26'h2A5);
      do_ar(line_base(26'h2A5), 0);
      do_r(0, 0, -1, 2'b00, 1'b0);
      do_ar(line_base(26'h2A5) + 32'h10, 0);
      do_r(1, 0, 0, 2'b10, 1'b0);
      do_ar(line_base(26'h2A5) + 32'h10, 0);
      do_r(1, 1, -1, 2'b00, 1'b0);
      do_ar(line_base(26'h2A5) + 32'h20, 0);
      do_r(2, 0, 1, 2'b00, 1'b1);
      do_ar(line_base(26'h2A5) + 32'h20, 0);
      do_r(2, 1, 0, 2'b11, 1'b0);
      do_ar(line_base(26'h2A5) + 32'h20, 0);
      do_r(2, 2, -1, 2'b00, 1'b0);
      do_ar(line_base(26'h2A5) + 32'h30, 5);
      do_r(3, 0, -1, 2'b00, 1'b0);
      end_fill(1'b0);
      chk("retry_ar_count", 64'(ar_hs - ar0), 64'd7);
      chk("retry_no_error", 64'(err_pulses - ep0), 64'd0);
      for (int i = 0; i < 8; i++) chk("retry_ram", dut_ram[i], exp_ram[i]);

      // Retries exhausted on burst 1
      ar0 = ar_hs; ep0 = err_pulses;
      start_fill(26'h3);
      do_ar(line_base(26'h3), 0);
      do_r(0, 0, -1, 2'b00, 1'b0);
      for (int a = 0; a < 3; a++) begin
         do_ar(line_base(26'h3) + 32'h10, 0);
         do_r(1, a, 0, 2'b11, 1'b0);
      end
      @(negedge clk);
      chk("abort_error_pulse", 64'(error), 64'd1);
      chk("abort_replace", 64'(replace), 64'd1);
      @(negedge clk);
      chk("abort_idle", 64'({replace, error}), 64'd0);
      chk("abort_ar_count", 64'(ar_hs - ar0), 64'd4);
      chk("abort_one_pulse", 64'(err_pulses - ep0), 64'd1);
      chk("abort_sb_drained", 64'(exp_q.size()), 64'd0);

      // Reset mid-DATA, then a clean fill from burst 0
      start_fill(26'h7);
      do_ar(line_base(26'h7), 0);
      do_r(0, 0, -1, 2'b00, 1'b0);
      do_ar(line_base(26'h7) + 32'h10, 0);
      beat_drive_and_reset();
      chk("mrst_outputs", 64'({replace, arvalid, rready, read_valid, error}), 64'd0);
      chk("mrst_read_addr", 64'(read_addr), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      ar0 = ar_hs; ep0 = err_pulses;
      start_fill(26'h9);
      for (int b = 0; b < 4; b++) begin
         do_ar(line_base(26'h9) + 32'(b * 16), 0);
         do_r(b, 0, -1, 2'b00, 1'b0);
      end
      end_fill(1'b0);
      chk("post_rst_ar_count", 64'(ar_hs - ar0), 64'd4);
      chk("post_rst_no_error", 64'(err_pulses - ep0), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   task automatic beat_drive_and_reset();
      beat_t e;
      e.addr = 3'd2;
      e.data = 64'h0BAD_F00D_0000_0002;
      rvalid = 1'b1; rdata = e.data; rlast = 1'b0; rresp = 2'b00; rid = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      #1 rst_n = 1'b0;
      rvalid = 1'b0;
      #1;
   endtask

endmodule
